// File: rtl/data_req_bridge_pkg.sv
// Shared types and constants for the data-side request bridge.
package data_req_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/data_req_bridge.sv
// Single-outstanding bridge from the core data port to the bus rd/wr channels.
// Define DATA_BRIDGE_WR_RESP_EN to hold store completion until wr_bvalid.
module data_req_bridge
  import data_req_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid,
  input  logic                data_op,
  input  logic [2:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                rd_req,
  output logic [2:0]          rd_size,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [DATA_W-1:0]   ret_data,
  output logic                wr_req,
  output logic [2:0]          wr_size,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W/8-1:0] wr_wstrb,
  output logic [DATA_W-1:0]   wr_data,
  input  logic                wr_rdy,
  input  logic                wr_bvalid,
  output logic [2:0]          bridge_state
);

  // Handshake: the requester holds data_valid and its fields until data_addr_ok
  // is seen high in a cycle; only IDLE accepts. rd_req/wr_req stay high until
  // the matching rd_rdy/wr_rdy, and data_data_ok is a single-cycle pulse.

  state_t              state, state_next;
  logic                op_q;
  logic [2:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   resp_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_LOAD;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (data_addr_ok) begin
      op_q    <= data_op;
      size_q  <= data_size;
      addr_q  <= data_addr;
      wstrb_q <= data_wstrb;
      wdata_q <= data_wdata;
    end
  end

  // Every beat overwrites the response word so the last beat is what returns.
  always_ff @(posedge clk) begin
    if (reset)
      resp_q <= '0;
    else if (state == RD_WAIT && ret_valid && op_q == OP_LOAD)
      resp_q <= ret_data;
  end

  always_comb begin
    state_next   = state;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    case (state)
      IDLE: begin
        data_addr_ok = data_valid;
        if (data_valid) state_next = (data_op == OP_STORE) ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        rd_req = 1'b1;
        if (rd_rdy) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (ret_valid && ret_last) state_next = RESP;
      end
      WR_REQ: begin
        wr_req = 1'b1;
`ifdef DATA_BRIDGE_WR_RESP_EN
        if (wr_rdy) state_next = WR_WAIT;
`else
        if (wr_rdy) state_next = RESP;
`endif
      end
      WR_WAIT: begin
`ifdef DATA_BRIDGE_WR_RESP_EN
        if (wr_bvalid) state_next = RESP;
`else
        state_next = IDLE;
`endif
      end
      RESP: begin
        data_data_ok = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifndef DATA_BRIDGE_WR_RESP_EN
  // Posted writes never look at the write response.
  logic unused_bvalid;
  assign unused_bvalid = wr_bvalid;
`endif

  assign data_rdata   = resp_q;
  assign rd_size      = size_q;
  assign rd_addr      = addr_q;
  assign wr_size      = size_q;
  assign wr_addr      = addr_q;
  assign wr_wstrb     = wstrb_q;
  assign wr_data      = wdata_q;
  assign bridge_state = state;

endmodule

// File: tb/tb_data_req_bridge.sv
// Directed bench for data_req_bridge: per-cycle vector table plus hand sequences
// for store, backpressure and mid-transaction reset.
module tb_data_req_bridge;
  import data_req_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_valid, data_op;
  logic [2:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0]  rd_size, wr_size;
  logic [31:0] rd_addr, ret_data, wr_addr, wr_data;
  logic        wr_req, wr_rdy, wr_bvalid;
  logic [3:0]  wr_wstrb;
  logic [2:0]  bridge_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  data_req_bridge dut (
    .clk(clk), .reset(reset),
    .data_valid(data_valid), .data_op(data_op), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .rd_req(rd_req), .rd_size(rd_size), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_size(wr_size), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_bvalid(wr_bvalid),
    .bridge_state(bridge_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic op, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic rrdy, input logic rv,
                       input logic rl, input logic [31:0] rdat, input logic wrdy,
                       input logic bv);
    data_valid = v;  data_op = op;  data_size = sz;  data_addr = addr;
    data_wstrb = strb;  data_wdata = wd;  rd_rdy = rrdy;  ret_valid = rv;
    ret_last = rl;  ret_data = rdat;  wr_rdy = wrdy;  wr_bvalid = bv;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard: every data_ok pulse must match the oldest expected response.
  always @(negedge clk) begin
    #2;
    if (data_data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=%h expected=no_response", data_rdata);
      end else begin
        check("resp_data", data_rdata, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        v, op;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic        rrdy, rv, rl;
    logic [31:0] rdat;
    logic        bv;
    logic        e_aok, e_dok, e_rq;
    logic [31:0] e_rdata;
    state_t      e_st;
    logic [31:0] e_raddr;
  } vec_t;

  function automatic vec_t mk(logic v, logic op, logic [2:0] sz, logic [31:0] addr,
                              logic rrdy, logic rv, logic rl, logic [31:0] rdat,
                              logic bv, logic e_aok, logic e_dok, logic e_rq,
                              logic [31:0] e_rdata, state_t e_st, logic [31:0] e_raddr);
    vec_t r;
    r.v = v; r.op = op; r.sz = sz; r.addr = addr; r.rrdy = rrdy; r.rv = rv;
    r.rl = rl; r.rdat = rdat; r.bv = bv; r.e_aok = e_aok; r.e_dok = e_dok;
    r.e_rq = e_rq; r.e_rdata = e_rdata; r.e_st = e_st; r.e_raddr = e_raddr;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // Reset block.
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state, single-beat load word, multi-beat load, stray beats in IDLE.
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,0,0,32'h0,        IDLE,   32'h0));
    tbl.push_back(mk(1,0,2,32'h1C00_0010, 0,0,0,32'h0,        0, 1,0,0,32'h0,        IDLE,   32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         1,0,0,32'h0,        0, 0,0,1,32'h0,        RD_REQ, 32'h1C00_0010));
    tbl.push_back(mk(0,0,0,32'h0,         0,1,1,32'hDEAD_BEEF,0, 0,0,0,32'h0,        RD_WAIT,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,1,0,32'hDEAD_BEEF,RESP,   32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,0,0,32'hDEAD_BEEF,IDLE,   32'h0));
    tbl.push_back(mk(1,0,0,32'h1C00_0021, 0,0,0,32'h0,        0, 1,0,0,32'hDEAD_BEEF,IDLE,   32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,0,1,32'hDEAD_BEEF,RD_REQ, 32'h1C00_0021));
    tbl.push_back(mk(0,0,0,32'h0,         1,0,0,32'h0,        0, 0,0,1,32'hDEAD_BEEF,RD_REQ, 32'h1C00_0021));
    tbl.push_back(mk(0,0,0,32'h0,         0,1,0,32'h1111_1111,0, 0,0,0,32'hDEAD_BEEF,RD_WAIT,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,0,0,32'h1111_1111,RD_WAIT,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,1,1,32'h2222_2222,0, 0,0,0,32'h1111_1111,RD_WAIT,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,1,0,32'h2222_2222,RESP,   32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,1,1,32'h3333_3333,1, 0,0,0,32'h2222_2222,IDLE,   32'h0));
    tbl.push_back(mk(0,0,0,32'h0,         0,0,0,32'h0,        0, 0,0,0,32'h2222_2222,IDLE,   32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].sz, tbl[i].addr, 4'h0, 32'h0, tbl[i].rrdy,
            tbl[i].rv, tbl[i].rl, tbl[i].rdat, 1'b0, tbl[i].bv);
      #1;
      check($sformatf("v%0d_addr_ok", i), {31'b0, data_addr_ok}, {31'b0, tbl[i].e_aok});
      check($sformatf("v%0d_data_ok", i), {31'b0, data_data_ok}, {31'b0, tbl[i].e_dok});
      check($sformatf("v%0d_rd_req", i), {31'b0, rd_req}, {31'b0, tbl[i].e_rq});
      check($sformatf("v%0d_wr_req", i), {31'b0, wr_req}, 32'h0);
      check($sformatf("v%0d_rdata", i), data_rdata, tbl[i].e_rdata);
      check($sformatf("v%0d_state", i), {29'b0, bridge_state}, {29'b0, tbl[i].e_st});
      if (tbl[i].e_rq) begin
        check($sformatf("v%0d_rd_addr", i), rd_addr, tbl[i].e_raddr);
        check($sformatf("v%0d_rd_size", i), {29'b0, rd_size}, {29'b0, tbl[i].e_raddr[5] ? SIZE_B : SIZE_W});
      end
      if (tbl[i].e_dok) exp_q.push_back(tbl[i].e_rdata);
      @(negedge clk);
    end

    // Store byte with wr_rdy already high.
    drive(1, 1, SIZE_B, 32'h0000_0103, 4'h8, 32'h5500_0000, 0, 0, 0, 0, 1, 0);
    #1;
    check("st_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("st_wr_req", {31'b0, wr_req}, 32'h1);
    check("st_wr_addr", wr_addr, 32'h0000_0103);
    check("st_wr_wstrb", {28'b0, wr_wstrb}, 32'h8);
    check("st_wr_data", wr_data, 32'h5500_0000);
    check("st_wr_size", {29'b0, wr_size}, {29'b0, SIZE_B});
    check("st_c1_data_ok", {31'b0, data_data_ok}, 32'h0);
    @(negedge clk);
`ifdef DATA_BRIDGE_WR_RESP_EN
    for (int c = 2; c <= 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (c == 4));
      #1;
      check($sformatf("st_c%0d_data_ok", c), {31'b0, data_data_ok}, 32'h0);
      check($sformatf("st_c%0d_state", c), {29'b0, bridge_state}, {29'b0, WR_WAIT});
      @(negedge clk);
    end
    idle();
    #1;
    check("st_c5_data_ok", {31'b0, data_data_ok}, 32'h1);
`else
    idle();
    #1;
    check("st_c2_data_ok", {31'b0, data_data_ok}, 32'h1);
`endif
    check("st_wr_req_done", {31'b0, wr_req}, 32'h0);
    exp_q.push_back(32'h2222_2222);
    @(negedge clk);
    #1;
    check("st_after_data_ok", {31'b0, data_data_ok}, 32'h0);
    check("st_after_state", {29'b0, bridge_state}, {29'b0, IDLE});
    @(negedge clk);

    // Backpressure with a second request held behind the first.
    drive(1, 0, SIZE_W, 32'h0000_0040, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("bp_first_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, SIZE_W, 32'h0000_0080, 0, 0, (c == 5), 0, 0, 0, 0, 0);
      #1;
      check($sformatf("bp%0d_rd_req", c), {31'b0, rd_req}, 32'h1);
      check($sformatf("bp%0d_addr_ok", c), {31'b0, data_addr_ok}, 32'h0);
      check($sformatf("bp%0d_rd_addr", c), rd_addr, 32'h0000_0040);
      @(negedge clk);
    end
    drive(1, 0, SIZE_W, 32'h0000_0080, 0, 0, 1, 1, 1, 32'hAAAA_5555, 0, 0);
    #1;
    check("bp_wait_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    @(negedge clk);
    drive(1, 0, SIZE_W, 32'h0000_0080, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("bp_resp_data_ok", {31'b0, data_data_ok}, 32'h1);
    check("bp_resp_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    exp_q.push_back(32'hAAAA_5555);
    @(negedge clk);
    #1;
    check("bp_second_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check("bp_second_rd_addr", rd_addr, 32'h0000_0080);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5A5A_5A5A, 0, 0);
    @(negedge clk);
    idle();
    #1;
    check("bp_second_data_ok", {31'b0, data_data_ok}, 32'h1);
    exp_q.push_back(32'h5A5A_5A5A);
    @(negedge clk);

    // Reset while waiting for read data, then a stray return beat.
    drive(1, 0, SIZE_W, 32'h1C00_0100, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    check("rst_pre_state", {29'b0, bridge_state}, {29'b0, RD_WAIT});
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h9999_9999, 0, 0);
    #1;
    check("rst_state", {29'b0, bridge_state}, {29'b0, IDLE});
    check("rst_data_ok", {31'b0, data_data_ok}, 32'h0);
    check("rst_rd_req", {31'b0, rd_req}, 32'h0);
    check("rst_wr_req", {31'b0, wr_req}, 32'h0);
    check("rst_rdata", data_rdata, 32'h0);
    check("rst_rd_addr", rd_addr, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_wr_wstrb", {28'b0, wr_wstrb}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("rst_stray_rdata", data_rdata, 32'h0);
    check("rst_stray_data_ok", {31'b0, data_data_ok}, 32'h0);
    @(negedge clk);
    #3;
    check("resp_queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
